// File: rtl/psk_nco_pkg.sv
// Package for the PSK NCO modulator.
// Holds the mode encodings, the quadrant-offset type and mapping helpers,
// and the elaboration-time quarter-wave sine generator that fills the ROM.
package psk_nco_pkg;

  // Modulation mode encodings (mode input / latched cur_mode)
  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;

  // Phase offset in quarter-turns (units of 2^LUT_AW phase steps)
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // Fixed-point format used only while building the sine table
  localparam int unsigned FX_FRAC = 30;
  localparam longint      PI_FX   = 64'sd3373259426;  // round(pi * 2^30)

  // Gray-coded QPSK: adjacent constellation points differ in one bit
  function automatic quad_t qpsk_gray_off(input logic [1:0] sym);
    quad_t q;
    case (sym)
      2'b01:   q = QUAD_1;
      2'b11:   q = QUAD_2;
      2'b10:   q = QUAD_3;
      default: q = QUAD_0;
    endcase
    return q;
  endfunction

  // BPSK: bit0 selects a half-turn
  function automatic quad_t bpsk_off(input logic bit0);
    return bit0 ? QUAD_2 : QUAD_0;
  endfunction

  // round(amp * sin(pi/2 * idx / 2^aw)), evaluated with an integer Taylor
  // series so the table is a pure constant and needs no init file.
  function automatic int unsigned quarter_sine(input int unsigned amp,
                                               input int unsigned aw,
                                               input int unsigned idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    x    = (PI_FX * longint'(idx)) / (longint'(2) << aw);
    x2   = (x * x) >>> FX_FRAC;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> FX_FRAC) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    scaled = (sum * longint'(amp) + (longint'(1) << (FX_FRAC - 1))) >>> FX_FRAC;
    if (scaled < 0) scaled = 0;
    return 32'(scaled);
  endfunction

endpackage

// File: rtl/psk_nco_mod_quarter_sine_rom.sv
// quarter_sine_rom: synchronous-read quarter-wave sine ROM, output stage S2.
// Contents: ROM[i] = round((2^MAG_W-1) * sin(pi/2 * i / 2^LUT_AW)), built at
// elaboration. The registered read also applies the sign, so the output is
// a finished two's-complement sample.
// Ports:
//   clk, rst    clock / async active-high reset
//   addr_i      folded quarter-wave address (from S1)
//   neg_i       negate the looked-up magnitude (from S1)
//   vld_i       S1 carries a real sample
//   data_o      signed sample, MAG_W+1 bits; holds when vld_i=0
//   valid_o     data_o updated this cycle
module quarter_sine_rom
  import psk_nco_pkg::*;
#(
  parameter int unsigned MAG_W  = 7,
  parameter int unsigned LUT_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr_i,
  input  logic              neg_i,
  input  logic              vld_i,
  output logic [MAG_W:0]    data_o,
  output logic              valid_o
);

  localparam int unsigned DEPTH = 1 << LUT_AW;
  localparam int unsigned AMP   = (1 << MAG_W) - 1;

  // Pack all entries into one constant vector, entry i at bits [i*MAG_W +: MAG_W]
  function automatic logic [DEPTH*MAG_W-1:0] build_table();
    logic [DEPTH*MAG_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      t[i*MAG_W +: MAG_W] = MAG_W'(quarter_sine(AMP, LUT_AW, i));
    end
    return t;
  endfunction

  localparam logic [DEPTH*MAG_W-1:0] SINE_TABLE = build_table();

  logic [MAG_W-1:0] mag_c;
  logic [MAG_W:0]   data_d;
  logic [MAG_W:0]   data_q;
  logic             valid_q;

  // Lookup and sign; magnitude <= 2^MAG_W-1 so negation cannot overflow
  always_comb begin
    mag_c  = SINE_TABLE[32'(addr_i) * MAG_W +: MAG_W];
    data_d = neg_i ? -{1'b0, mag_c} : {1'b0, mag_c};
  end

  // Output register: only real samples update the held value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= vld_i;
      if (vld_i) data_q <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/psk_nco_mod.sv
// psk_nco_mod: NCO-based BPSK / Gray-QPSK modulator.
// A phase accumulator advanced by fcw_i on each en_i cycle indexes a folded
// quarter-wave sine ROM; the current symbol adds a quarter-turn multiple to
// the phase. Symbols are taken over a valid/ready handshake at symbol
// boundaries and take effect from the following sample.
// Ports:
//   clk, rst       clock / async active-high reset
//   en_i           sample strobe, one sample per en_i cycle
//   fcw_i          frequency control word, used every en_i cycle
//   sps_i          samples per symbol (0 behaves as 1)
//   mode_i         0 BPSK, 1 QPSK; latched with the symbol
//   sym_data_i     symbol bits (BPSK uses bit0)
//   sym_valid_i    symbol offered
//   sym_ready_o    boundary on an en_i cycle (combinational)
//   out_o          signed sample, 2 clk after its en_i cycle
//   out_valid_o    out_o carries a new sample
//   underrun_o     sticky: a boundary passed with no symbol offered
module psk_nco_mod
  import psk_nco_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 6,
  parameter int unsigned SPS_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] fcw_i,
  input  logic [SPS_W-1:0]   sps_i,
  input  logic               mode_i,
  input  logic [1:0]         sym_data_i,
  input  logic               sym_valid_i,
  output logic               sym_ready_o,
  output logic [WIDTH-1:0]   out_o,
  output logic               out_valid_o,
  output logic               underrun_o
);

  localparam int unsigned P_W = LUT_AW + 2;  // phase index incl. quadrant

  // Symbol / accumulator state
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [SPS_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cur_sym_q, cur_sym_d;
  logic               cur_mode_q, cur_mode_d;
  logic               underrun_q, underrun_d;
  logic               start_q, start_d;     // forces the first en cycle to be a boundary

  // Stage S1
  logic [LUT_AW-1:0]  addr_q, addr_d;
  logic               neg_q, neg_d;
  logic               vld_q;

  logic [SPS_W-1:0]   eff_sps_c;
  logic               boundary_c;
  quad_t              quad_off_c;
  logic [P_W-1:0]     phase_c;
  logic [1:0]         quad_c;
  logic [LUT_AW-1:0]  a_c;

  // Boundary detect; >= keeps the counter safe when sps shrinks mid-symbol
  always_comb begin
    eff_sps_c   = (sps_i == '0) ? SPS_W'(1) : sps_i;
    boundary_c  = start_q | (cnt_q >= (eff_sps_c - SPS_W'(1)));
    sym_ready_o = en_i & boundary_c;
  end

  // Next-state for accumulator, counter and symbol handshake
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    cur_sym_d  = cur_sym_q;
    cur_mode_d = cur_mode_q;
    underrun_d = underrun_q;
    start_d    = start_q;
    if (en_i) begin
      acc_d   = acc_q + fcw_i;
      start_d = 1'b0;
      if (boundary_c) begin
        cnt_d = '0;
        if (sym_valid_i) begin
          cur_sym_d  = sym_data_i;
          cur_mode_d = mode_i;
        end else begin
          underrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + SPS_W'(1);
      end
    end
  end

  // Symbol offset, phase index and quadrant fold (uses acc before the add)
  always_comb begin
    quad_off_c = QUAD_0;
    case (cur_mode_q)
      MODE_BPSK: quad_off_c = bpsk_off(cur_sym_q[0]);
      MODE_QPSK: quad_off_c = qpsk_gray_off(cur_sym_q);
      default:   quad_off_c = QUAD_0;
    endcase
    phase_c = acc_q[PHASE_W-1 -: P_W] + {quad_off_c, {LUT_AW{1'b0}}};
    quad_c  = phase_c[P_W-1 -: 2];
    a_c     = phase_c[LUT_AW-1:0];
    // Quadrants 1/3 run the quarter wave backwards, 2/3 are negative
    addr_d  = quad_c[0] ? ~a_c : a_c;
    neg_d   = quad_c[1];
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      cur_sym_q  <= 2'b00;
      cur_mode_q <= MODE_BPSK;
      underrun_q <= 1'b0;
      start_q    <= 1'b1;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      cur_sym_q  <= cur_sym_d;
      cur_mode_q <= cur_mode_d;
      underrun_q <= underrun_d;
      start_q    <= start_d;
    end
  end

  // Stage S1: advances every cycle so the pipeline drains while en_i=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      neg_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      neg_q  <= neg_d;
      vld_q  <= en_i;
    end
  end

  // Stage S2: ROM read, sign and output register
  quarter_sine_rom #(
    .MAG_W  (WIDTH - 1),
    .LUT_AW (LUT_AW)
  ) u_rom (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr_q),
    .neg_i   (neg_q),
    .vld_i   (vld_q),
    .data_o  (out_o),
    .valid_o (out_valid_o)
  );

  assign underrun_o = underrun_q;

endmodule
